spi_slave_if: RTL and testbench
===============================

# spi_slave_if

SPI slave (responder) that lets an external SPI master exchange bytes with a block on the system clock domain. It is the far end of the SoC's SPI master port (`spi_clk`, `spi_mosi`, `spi_miso`, `spi_nss`), used as a bench/peripheral model and as an on-chip slave endpoint. The block oversamples all SPI pins on `clk` and runs SPI mode 0, MSB first. Each received byte is presented through a valid pulse, and each transmit byte is supplied through a one-entry ready/valid buffer.

## Interface
- `DATA_W`, default 8: bits per frame.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_clk`  in  1  serial clock from master; idle low.
- `spi_nss`  in  1  chip select, active low.
- `spi_mosi`  in  1  master-out data.
- `spi_miso`  out  1  slave-out data.
- `spi_miso_oe`  out  1  MISO output enable; high while selected.
- `tx_data`  in  DATA_W  next byte to send.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  transmit buffer empty.
- `rx_data`  out  DATA_W  last received byte.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` is updated.
- `tx_underrun`  out  1  one-cycle pulse when a frame starts with an empty buffer.

## Operation
- **Synchronizers:** `spi_clk`, `spi_nss` and `spi_mosi` each pass through a 2-flop synchronizer.
  - Reset values: `spi_clk` 0, `spi_nss` 1, `spi_mosi` 0.
  - Edge detection compares the synchronized value with a one-cycle-delayed copy.
- **States:**
  - IDLE: synchronized `spi_nss`=1.
  - ACTIVE: synchronized `spi_nss`=0.
- **IDLE→ACTIVE** (nss fall detected):
  - `bit_cnt`←0.
  - If the buffer is full, `tx_shift` is loaded from the buffer and the buffer is cleared.
  - Otherwise `tx_shift`←0x00 and `tx_underrun` pulses.
  - `spi_miso`←MSB of the loaded value; `spi_miso_oe`←1.
- **spi_clk rise in ACTIVE:**
  - `rx_shift`←{`rx_shift`[DATA_W-2:0], mosi_sync}; `bit_cnt`++.
  - When `bit_cnt` reaches DATA_W: `rx_data`←assembled byte, `rx_valid`=1 for one cycle, `bit_cnt`←0, and the reload flag is set.
- **spi_clk fall in ACTIVE:**
  - If the reload flag is set, `tx_shift` reloads from the buffer, or 0x00 plus a `tx_underrun` pulse if empty. The flag is cleared.
  - Otherwise `tx_shift` shifts left.
  - `spi_miso`←new MSB.
- **ACTIVE→IDLE** (nss rise):
  - Partial frame is discarded; no `rx_valid`.
  - `bit_cnt`←0; `spi_miso_oe`←0; `spi_miso`←0.
  - An unconsumed buffer entry is retained; the bits of a partially shifted byte are lost.
- **Transmit buffer:**
  - `tx_ready` = !full, registered.
  - Write when `tx_valid && tx_ready`.
  - `tx_valid` while full is ignored and the buffer is not overwritten.
- **Simultaneous write and empty-buffer load in one cycle:** the load sees empty, so 0x00 is sent and `tx_underrun` pulses. The new data is stored for the next frame.
- **No back-pressure on RX.** An unread `rx_data` is overwritten by the next byte.

## Timing
- Reset values:
  - `spi_miso`=0, `spi_miso_oe`=0, `tx_ready`=1.
  - `rx_data`=0, `rx_valid`=0, `tx_underrun`=0.
  - Internal: IDLE, counters 0, buffer empty.
- Pin-to-action latency is 3 `clk` edges (2 sync + 1 register):
  - `rx_valid` rises 3 edges after the 8th `spi_clk` rise.
  - MISO first bit is valid 3 edges after nss falls.
  - Later MISO bits are valid 3 edges after each `spi_clk` fall.
- Master requirements:
  - `spi_clk` high ≥4 `clk` periods and low ≥4 `clk` periods (max SCK = clk/8).
  - nss fall to first SCK rise ≥4 periods.
  - Last SCK fall to nss rise ≥4 periods.
- `tx_ready` returns high the cycle after a buffer load.
- Reset mid-frame: all outputs take reset values immediately (asynchronous); the frame is lost.

## Structure
- Shared defines: SPI fill byte (8'h00), nss inactive level, sync reset values.
- Sub-module `sync_2ff` (1-bit, reset-value parameter), instantiated three times.
- The rest is one module: state bit, counters, shift registers, buffer.

## Test plan
- Reset → `tx_ready`=1, `spi_miso_oe`=0, `rx_valid`=0, `rx_data`=0x00.
- Buffer 0x3C, master sends 0xA5 at SCK=clk/8 → `rx_data`=0xA5 with one `rx_valid` pulse; master reads 0x3C.
- Buffer 0x56, master sends 0x12,0x34 back-to-back → MISO bytes 0x56 then 0x00; one `tx_underrun` pulse; two `rx_valid` pulses, 0x12 then 0x34.
- nss rises after 5 bits of 0xC3, then a full frame 0xFF → no `rx_valid` for the partial frame; the next frame gives `rx_data`=0xFF.
- Buffer full (0x11), `tx_valid` with 0x22 held → `tx_ready`=0 and 0x22 rejected; the next frame sends 0x11.
- `rst` pulsed mid-frame after 4 bits → immediate reset values; a following frame 0x5A is received correctly.

Source files
------------

// File: rtl/spi_slave_if_pkg.sv
// ============================================================================
// Module   : spi_slave_if_pkg
// Desc     : Shared constants and state type for the SPI slave interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_slave_if_pkg;

    localparam logic [7:0] c_spi_fill_byte = 8'h00;
    localparam logic       c_nss_inactive  = 1'b1;

    localparam logic c_sync_rst_sck  = 1'b0;
    localparam logic c_sync_rst_nss  = c_nss_inactive;
    localparam logic c_sync_rst_mosi = 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Desc     : Single-bit two-flop synchronizer with configurable reset value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_if.sv
// ============================================================================
// Module   : spi_slave_if
// Desc     : Oversampled SPI mode-0 slave, MSB first, one-entry TX buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_if
    import spi_slave_if_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_nss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun
);

    localparam int                CNT_W       = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] c_fill_word = DATA_W'(c_spi_fill_byte);
    localparam logic [CNT_W-1:0]  c_last_bit  = CNT_W'(DATA_W - 1);

    logic sck_s, nss_s, mosi_s;

    sync_2ff #(.RST_VAL(c_sync_rst_sck))  u_sync_sck  (.clk(clk), .rst(rst), .d_i(spi_clk),  .q_o(sck_s));
    sync_2ff #(.RST_VAL(c_sync_rst_nss))  u_sync_nss  (.clk(clk), .rst(rst), .d_i(spi_nss),  .q_o(nss_s));
    sync_2ff #(.RST_VAL(c_sync_rst_mosi)) u_sync_mosi (.clk(clk), .rst(rst), .d_i(spi_mosi), .q_o(mosi_s));

    spi_state_e        state_q, state_d;
    logic              sck_prev_q, nss_prev_q;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              reload_q, reload_d;
    logic              oe_q, oe_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              tx_ready_q, tx_ready_d;

    logic              w_sck_rise, w_sck_fall, w_nss_rise, w_nss_fall;
    logic              w_fetch;
    logic [DATA_W-1:0] w_fetch_val;
    logic [DATA_W-1:0] w_rx_next;

    assign w_sck_rise = sck_s & ~sck_prev_q;
    assign w_sck_fall = ~sck_s & sck_prev_q;
    assign w_nss_fall = ~nss_s & nss_prev_q;
    assign w_nss_rise = nss_s & ~nss_prev_q;

    // The buffer is consumed at frame start and on the first SCK fall after a byte boundary.
    assign w_fetch = ((state_q == ST_IDLE) && w_nss_fall) ||
                     ((state_q == ST_ACTIVE) && !w_nss_rise && w_sck_fall && reload_q);
    assign w_fetch_val = buf_full_q ? buf_q : c_fill_word;
    assign w_rx_next   = {rx_shift_q, mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sck_prev_q <= c_sync_rst_sck;
            nss_prev_q <= c_nss_inactive;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            reload_q   <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sck_prev_q <= sck_s;
            nss_prev_q <= nss_s;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            reload_q   <= reload_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        reload_d   = reload_q;
        oe_d       = oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = w_fetch && !buf_full_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;

        case (state_q)
            ST_IDLE: begin
                if (w_nss_fall) begin
                    state_d    = ST_ACTIVE;
                    bit_cnt_d  = '0;
                    reload_d   = 1'b0;
                    tx_shift_d = w_fetch_val;
                    oe_d       = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_nss_rise) begin
                    state_d    = ST_IDLE;
                    bit_cnt_d  = '0;
                    reload_d   = 1'b0;
                    tx_shift_d = '0;
                    oe_d       = 1'b0;
                end else if (w_sck_rise) begin
                    rx_shift_d = w_rx_next[DATA_W-2:0];
                    if (bit_cnt_q == c_last_bit) begin
                        rx_data_d  = w_rx_next;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        reload_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (w_sck_fall) begin
                    if (reload_q) begin
                        tx_shift_d = w_fetch_val;
                        reload_d   = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load in the same cycle as a write sees the old (empty) buffer.
        if (w_fetch && buf_full_q) begin
            buf_full_d = 1'b0;
        end
        if (tx_valid && tx_ready_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
        tx_ready_d = !buf_full_d;
    end

    assign spi_miso    = tx_shift_q[DATA_W-1];
    assign spi_miso_oe = oe_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_if.sv
// ============================================================================
// Module   : tb_spi_slave_if
// Desc     : Self-checking bench for spi_slave_if driving a mode-0 master at clk/8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk, spi_nss, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, tx_underrun;

    int checks = 0;
    int errors = 0;
    int ur_cnt = 0;
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .spi_clk(spi_clk), .spi_nss(spi_nss), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun)
    );

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (tx_underrun) ur_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic buf_write(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Underrun count is snapshotted before the last SCK fall, which triggers the next-byte reload.
    task automatic spi_frame(input logic [15:0] mosi_w, input int nbits,
                             output logic [15:0] miso_w, output int ur_snap, output logic oe_seen);
        miso_w  = '0;
        oe_seen = 1'b0;
        ur_snap = ur_cnt;
        @(negedge clk);
        spi_nss  = 1'b0;
        spi_mosi = mosi_w[nbits-1];
        for (int i = 0; i < nbits; i++) begin
            repeat (4) @(negedge clk);
            miso_w[nbits-1-i] = spi_miso;
            if (i == 0) oe_seen = spi_miso_oe;
            spi_clk = 1'b1;
            repeat (4) @(negedge clk);
            if (i == nbits - 1) ur_snap = ur_cnt;
            spi_clk = 1'b0;
            if (i < nbits - 1) spi_mosi = mosi_w[nbits-2-i];
        end
        repeat (4) @(negedge clk);
        spi_nss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t       vecs[5];
    logic [15:0] mw;
    int          snap, ur0;
    logic        oe;

    initial begin
        vecs[0] = '{tx: 8'h3C, mosi: 8'hA5, exp_rx: 8'hA5, exp_miso: 8'h3C};
        vecs[1] = '{tx: 8'h81, mosi: 8'h7E, exp_rx: 8'h7E, exp_miso: 8'h81};
        vecs[2] = '{tx: 8'hFF, mosi: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF};
        vecs[3] = '{tx: 8'h00, mosi: 8'hFF, exp_rx: 8'hFF, exp_miso: 8'h00};
        vecs[4] = '{tx: 8'hC3, mosi: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hC3};

        rst = 1'b1; spi_clk = 1'b0; spi_nss = 1'b1; spi_mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_oe", spi_miso_oe, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_miso", spi_miso, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            rxq.delete();
            chk("vec_ready_before", tx_ready, 1);
            buf_write(vecs[v].tx);
            chk("vec_ready_full", tx_ready, 0);
            ur0 = ur_cnt;
            spi_frame({8'h00, vecs[v].mosi}, 8, mw, snap, oe);
            chk("vec_oe_active", oe, 1);
            chk("vec_miso", mw[7:0], vecs[v].exp_miso);
            chk("vec_underrun", snap - ur0, 0);
            chk("vec_rx_count", rxq.size(), 1);
            if (rxq.size() > 0) chk("vec_rx_data", rxq[0], vecs[v].exp_rx);
            chk("vec_oe_idle", spi_miso_oe, 0);
            chk("vec_miso_idle", spi_miso, 0);
            chk("vec_ready_after", tx_ready, 1);
        end

        // Two back-to-back bytes with only the first one buffered.
        rxq.delete();
        buf_write(8'h56);
        ur0 = ur_cnt;
        spi_frame(16'h1234, 16, mw, snap, oe);
        chk("b2b_miso", mw, 16'h5600);
        chk("b2b_underrun", snap - ur0, 1);
        chk("b2b_rx_count", rxq.size(), 2);
        if (rxq.size() == 2) begin
            chk("b2b_rx0", rxq[0], 8'h12);
            chk("b2b_rx1", rxq[1], 8'h34);
        end

        // Partial frame of 0xC3 (5 bits), then a full 0xFF.
        rxq.delete();
        spi_frame(16'h0018, 5, mw, snap, oe);
        chk("partial_no_rx", rxq.size(), 0);
        ur0 = ur_cnt;
        spi_frame(16'h00FF, 8, mw, snap, oe);
        chk("after_partial_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("after_partial_rx", rxq[0], 8'hFF);
        chk("after_partial_miso", mw[7:0], 8'h00);
        chk("after_partial_underrun", snap - ur0, 1);

        // Write while full is rejected.
        buf_write(8'h11);
        @(negedge clk);
        tx_data = 8'h22; tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_ready_low", tx_ready, 0);
        tx_valid = 1'b0;
        spi_frame(16'h0077, 8, mw, snap, oe);
        chk("full_keeps_first", mw[7:0], 8'h11);
        rxq.delete();
        spi_frame(16'h0077, 8, mw, snap, oe);
        chk("full_second_rejected", mw[7:0], 8'h00);
        chk("full_rx", rx_data, 8'h77);

        // Asynchronous reset mid-frame after 4 bits, with a buffered byte pending.
        @(negedge clk);
        spi_nss = 1'b0; spi_mosi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            spi_clk = 1'b1;
            repeat (4) @(negedge clk);
            spi_clk = 1'b0;
        end
        buf_write(8'hAB);
        chk("mid_ready_full", tx_ready, 0);
        chk("mid_oe", spi_miso_oe, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_oe", spi_miso_oe, 0);
        chk("rst_async_miso", spi_miso, 0);
        chk("rst_async_ready", tx_ready, 1);
        chk("rst_async_rx_data", rx_data, 8'h00);
        chk("rst_async_rx_valid", rx_valid, 0);
        chk("rst_async_underrun", tx_underrun, 0);
        spi_nss = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rxq.delete();
        buf_write(8'h3C);
        spi_frame(16'h005A, 8, mw, snap, oe);
        chk("post_rst_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("post_rst_rx", rxq[0], 8'h5A);
        chk("post_rst_miso", mw[7:0], 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
